// File: rtl/regfile_pkg.sv
// Shared types and constants for the ARMv8 integer register file.
package regfile_pkg;

    localparam int DW = 64;
    localparam int NREG = 32;
    localparam logic [4:0] ZERO_REG = 5'd31;

    typedef logic [4:0]    reg_idx_t;
    typedef logic [DW-1:0] reg_data_t;

endpackage

// File: rtl/regfile_32x64_decoder5_32.sv
// 5:32 one-hot decoder with enable; all outputs low when disabled.
module decoder5_32 (
    input  logic        e,
    input  logic [4:0]  addr,
    output logic [31:0] y
);

    // One-hot select of the addressed line when enabled
    always_comb begin
        y = '0;
        if (e) begin
            y[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_32x64.sv
// 32 x 64-bit integer register file, two read ports, one write port,
// XZR at index 31, write-through bypass and pending-write scoreboard.
module regfile_32x64
    import regfile_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          RegWrite,
    input  logic [4:0]    WriteRegister,
    input  logic [DW-1:0] WriteData,
    input  logic [4:0]    ReadRegister1,
    input  logic [4:0]    ReadRegister2,
    output logic [DW-1:0] ReadData1,
    output logic [DW-1:0] ReadData2,
    input  logic          issue_valid,
    input  logic [4:0]    issue_rd,
    output logic          rd1_pending,
    output logic          rd2_pending
);

    reg_data_t         regs [NREG];
    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   dec_y;
    logic [NREG-1:0]   we;
    logic [NREG-1:0]   set_vec;
    logic              hit1;
    logic              hit2;

    decoder5_32 u_wdec (
        .e    (RegWrite),
        .addr (WriteRegister),
        .y    (dec_y)
    );

    // Write enables: decoder output with the XZR line masked off
    always_comb begin
        we           = dec_y;
        we[ZERO_REG] = 1'b0;
    end

    // Scoreboard set vector from the issuing instruction (never XZR)
    always_comb begin
        set_vec = '0;
        if (issue_valid && (issue_rd != ZERO_REG)) begin
            set_vec[issue_rd] = 1'b1;
        end
    end

    // Register array: async clear, per-entry write on the rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (we[i]) begin
                    regs[i] <= WriteData;
                end
            end
        end
    end

    // Pending bits: writeback clears, issue sets; set wins on the same index
    // because the issuing instruction is younger than the retiring one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~we) | set_vec;
        end
    end

    assign hit1 = RegWrite && (WriteRegister == ReadRegister1);
    assign hit2 = RegWrite && (WriteRegister == ReadRegister2);

    // Read port 1: array, then bypass, then XZR / reset force to zero
    always_comb begin
        ReadData1 = regs[ReadRegister1];
        if (hit1) begin
            ReadData1 = WriteData;
        end
        if ((ReadRegister1 == ZERO_REG) || !rst_n) begin
            ReadData1 = '0;
        end
    end

    // Read port 2: array, then bypass, then XZR / reset force to zero
    always_comb begin
        ReadData2 = regs[ReadRegister2];
        if (hit2) begin
            ReadData2 = WriteData;
        end
        if ((ReadRegister2 == ZERO_REG) || !rst_n) begin
            ReadData2 = '0;
        end
    end

    // A same-cycle writeback to the read index satisfies the hazard
    always_comb begin
        rd1_pending = rst_n && pending[ReadRegister1] && !hit1;
        rd2_pending = rst_n && pending[ReadRegister2] && !hit2;
    end

endmodule

// File: tb/tb_regfile_32x64.sv
// Self-checking bench for regfile_32x64: behavioural model compared every
// cycle, plus hand-computed literal checks for the directed scenarios.
module tb_regfile_32x64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RegWrite = 1'b0;
    logic [4:0]  WriteRegister = '0;
    logic [63:0] WriteData = '0;
    logic [4:0]  ReadRegister1 = '0;
    logic [4:0]  ReadRegister2 = '0;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        rd1_pending;
    logic        rd2_pending;

    int total = 0;
    int bad = 0;

    logic [63:0] m_reg [32];
    logic        m_pend [32];

    regfile_32x64 dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .rd1_pending   (rd1_pending),
        .rd2_pending   (rd2_pending)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Architectural model: what the register file must hold after each edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i]  = '0;
                m_pend[i] = 1'b0;
            end
        end else begin
            if (RegWrite) begin
                m_pend[WriteRegister] = 1'b0;
                if (WriteRegister != 5'd31) m_reg[WriteRegister] = WriteData;
            end
            if (issue_valid && issue_rd != 5'd31) m_pend[issue_rd] = 1'b1;
        end
    end

    function automatic logic [63:0] exp_rd(input logic [4:0] ra);
        if (!rst_n || ra == 5'd31) return 64'd0;
        if (RegWrite && WriteRegister == ra) return WriteData;
        return m_reg[ra];
    endfunction

    function automatic logic exp_pend(input logic [4:0] ra);
        if (!rst_n) return 1'b0;
        if (RegWrite && WriteRegister == ra) return 1'b0;
        return m_pend[ra];
    endfunction

    // Per-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        logic [63:0] e1, e2;
        logic        p1, p2;
        e1 = exp_rd(ReadRegister1);
        e2 = exp_rd(ReadRegister2);
        p1 = exp_pend(ReadRegister1);
        p2 = exp_pend(ReadRegister2);
        total += 4;
        if (ReadData1 !== e1) begin
            bad++;
            $display("FAIL model_rd1 t=%0t idx=%0d got=%h exp=%h", $time, ReadRegister1, ReadData1, e1);
        end
        if (ReadData2 !== e2) begin
            bad++;
            $display("FAIL model_rd2 t=%0t idx=%0d got=%h exp=%h", $time, ReadRegister2, ReadData2, e2);
        end
        if (rd1_pending !== p1) begin
            bad++;
            $display("FAIL model_pend1 t=%0t idx=%0d got=%0b exp=%0b", $time, ReadRegister1, rd1_pending, p1);
        end
        if (rd2_pending !== p2) begin
            bad++;
            $display("FAIL model_pend2 t=%0t idx=%0d got=%0b exp=%0b", $time, ReadRegister2, rd2_pending, p2);
        end
    end

    task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs just after the rising edge, then let them settle
    task automatic drive(input logic rw, input logic [4:0] wr, input logic [63:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2,
                         input logic iv, input logic [4:0] ird);
        @(posedge clk);
        #1;
        RegWrite      = rw;
        WriteRegister = wr;
        WriteData     = wd;
        ReadRegister1 = r1;
        ReadRegister2 = r2;
        issue_valid   = iv;
        issue_rd      = ird;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 1'b0;
        end

        // Reset: a write presented during reset must be discarded and masked
        drive(1'b1, 5'd4, 64'hABCD, 5'd4, 5'd4, 1'b1, 5'd4);
        lit("reset_rd1_masked", ReadData1, 64'd0);
        lit("reset_pend1", {63'd0, rd1_pending}, 64'd0);
        drive(1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 1'b0, 5'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All entries read zero after reset
        for (int i = 0; i < 31; i += 2) begin
            drive(1'b0, 5'd0, 64'd0, 5'(i), 5'(i + 1), 1'b0, 5'd0);
        end
        drive(1'b0, 5'd0, 64'd0, 5'd4, 5'd30, 1'b0, 5'd0);
        lit("post_reset_x4", ReadData1, 64'd0);
        lit("post_reset_x30", ReadData2, 64'd0);

        // Basic write then read next cycle
        drive(1'b1, 5'd5, 64'hDEADBEEF_CAFEF00D, 5'd0, 5'd0, 1'b0, 5'd0);
        drive(1'b0, 5'd0, 64'd0, 5'd5, 5'd6, 1'b0, 5'd0);
        lit("basic_x5", ReadData1, 64'hDEADBEEF_CAFEF00D);
        lit("basic_x6", ReadData2, 64'd0);

        // XZR: write dropped, reads zero, issue to 31 never pends
        drive(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31, 1'b1, 5'd31);
        lit("xzr_same_rd1", ReadData1, 64'd0);
        lit("xzr_same_rd2", ReadData2, 64'd0);
        drive(1'b0, 5'd0, 64'd0, 5'd31, 5'd31, 1'b0, 5'd0);
        lit("xzr_next_rd1", ReadData1, 64'd0);
        lit("xzr_next_rd2", ReadData2, 64'd0);
        lit("xzr_pend1", {63'd0, rd1_pending}, 64'd0);

        // Bypass on both ports to the same register
        drive(1'b1, 5'd7, 64'h1, 5'd0, 5'd0, 1'b0, 5'd0);
        drive(1'b1, 5'd7, 64'h22, 5'd7, 5'd7, 1'b0, 5'd0);
        lit("bypass_rd1", ReadData1, 64'h22);
        lit("bypass_rd2", ReadData2, 64'h22);
        drive(1'b0, 5'd0, 64'd0, 5'd7, 5'd5, 1'b0, 5'd0);
        lit("after_bypass_x7", ReadData1, 64'h22);

        // Scoreboard: issue X3 at cycle 0, writeback at cycle 4
        drive(1'b0, 5'd0, 64'd0, 5'd3, 5'd0, 1'b1, 5'd3);
        lit("sb_c0_pend", {63'd0, rd1_pending}, 64'd0);
        drive(1'b0, 5'd0, 64'd0, 5'd3, 5'd0, 1'b0, 5'd0);
        lit("sb_c1_pend", {63'd0, rd1_pending}, 64'd1);
        drive(1'b0, 5'd0, 64'd0, 5'd3, 5'd0, 1'b0, 5'd0);
        drive(1'b0, 5'd0, 64'd0, 5'd3, 5'd0, 1'b0, 5'd0);
        lit("sb_c3_pend", {63'd0, rd1_pending}, 64'd1);
        drive(1'b1, 5'd3, 64'h333, 5'd3, 5'd0, 1'b0, 5'd0);
        lit("sb_c4_pend_bypass", {63'd0, rd1_pending}, 64'd0);
        lit("sb_c4_data", ReadData1, 64'h333);
        drive(1'b0, 5'd0, 64'd0, 5'd3, 5'd0, 1'b0, 5'd0);
        lit("sb_c5_pend", {63'd0, rd1_pending}, 64'd0);

        // Set/clear collision on X9: set wins, data written
        drive(1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 1'b1, 5'd9);
        drive(1'b1, 5'd9, 64'h99, 5'd9, 5'd0, 1'b1, 5'd9);
        drive(1'b0, 5'd0, 64'd0, 5'd9, 5'd0, 1'b0, 5'd0);
        lit("collide_pend", {63'd0, rd1_pending}, 64'd1);
        lit("collide_data", ReadData1, 64'h99);

        // Clear X10 and set X11 in the same cycle
        drive(1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 1'b1, 5'd10);
        drive(1'b1, 5'd10, 64'hA0, 5'd0, 5'd0, 1'b1, 5'd11);
        drive(1'b0, 5'd0, 64'd0, 5'd10, 5'd11, 1'b0, 5'd0);
        lit("clr10_pend", {63'd0, rd1_pending}, 64'd0);
        lit("set11_pend", {63'd0, rd2_pending}, 64'd1);

        // Asynchronous reset mid-cycle with a write and an issue in flight
        drive(1'b1, 5'd12, 64'h1212, 5'd5, 5'd11, 1'b1, 5'd12);
        #1;
        rst_n = 1'b0;
        #1;
        lit("async_rd1", ReadData1, 64'd0);
        lit("async_pend2", {63'd0, rd2_pending}, 64'd0);
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        RegWrite      = 1'b0;
        issue_valid   = 1'b0;
        ReadRegister1 = 5'd12;
        ReadRegister2 = 5'd11;
        #1;
        lit("reset_drop_x12", ReadData1, 64'd0);
        lit("reset_clr_pend11", {63'd0, rd2_pending}, 64'd0);
        drive(1'b0, 5'd0, 64'd0, 5'd5, 5'd9, 1'b0, 5'd0);
        lit("reset_clr_x5", ReadData1, 64'd0);
        lit("reset_clr_pend9", {63'd0, rd2_pending}, 64'd0);
        drive(1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 1'b0, 5'd0);
        @(posedge clk);
        #2;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_32x64.md
Name: regfile_32x64

Overview:
- ARMv8 integer register file: 32 x 64-bit entries, two read ports and one write port.
- X31 reads as zero (XZR).
- Write-enable one-hot comes from the 5:32 write-address decoder, so this block directly consumes the decoder output.
- Adds write-through bypass and a per-register pending-write scoreboard that the decode stage uses for hazard stalls.

Parameters:
- DW, 64, data width per register
- NREG, 32, number of architectural registers (fixed by the 5-bit address; not a free parameter)
- ZERO_REG, 31, index hardwired to zero

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- RegWrite  in  1  writeback valid/write enable
- WriteRegister  in  5  writeback destination index
- WriteData  in  DW  writeback data
- ReadRegister1  in  5  read port 1 index
- ReadRegister2  in  5  read port 2 index
- ReadData1  out  DW  read port 1 data
- ReadData2  out  DW  read port 2 data
- issue_valid  in  1  decode issuing an instruction that will write issue_rd
- issue_rd  in  5  destination of issuing instruction
- rd1_pending  out  1  ReadRegister1 has an outstanding write not yet visible
- rd2_pending  out  1  ReadRegister2 has an outstanding write not yet visible

Behaviour:
- Reset: clk and reset port names are fixed; reset is asynchronous and active-low. On rst_n low, all 32 entries clear to 0 and all scoreboard bits clear to 0 immediately, without waiting for a clock edge.
- Reset outputs: ReadData1/2 = 0 and rd1/rd2_pending = 0 while in reset.
- Reset mid-operation: any write or issue in the same cycle is discarded.
- Write:
  - Write-enable is the decoder one-hot gated by RegWrite, with bit ZERO_REG forced to 0.
  - The selected entry updates on the rising edge of clk.
  - Writes to X31 are dropped silently.
- Read:
  - Combinational from the array.
  - Index 31 returns 0, regardless of any write.
- Bypass: if RegWrite=1 and WriteRegister==ReadRegisterN and the index != 31, ReadDataN = WriteData in the same cycle (write-through). Both ports bypass independently; both may hit the same register.
- Scoreboard: 32 pending bits, bit 31 tied to 0.
  - Set on the clock edge when issue_valid=1 and issue_rd != 31.
  - Cleared on the clock edge when RegWrite=1 for WriteRegister.
  - Simultaneous set and clear of the same index: set wins, because the issuing instruction is younger than the one retiring.
  - Set of one index and clear of another in the same cycle: both take effect.
- Pending outputs: rdN_pending = pending[ReadRegisterN] AND NOT (RegWrite AND WriteRegister==ReadRegisterN). A bypass satisfies the hazard in the same cycle.
- Latency:
  - Write to array visible: next cycle.
  - Write to read port via bypass: 0 cycles.
  - Issue to pending visible: next cycle.
- Overflow: a second issue to an already-pending register keeps the bit set (no counting). The pipeline is in order and the single writeback clears it. The team accepts that a WAW pair clears on the first writeback; decode must not issue a WAW to a pending register.

Decomposition:
- Shared package regfile_pkg holds:
  - DW = 64
  - ZERO_REG = 5'd31
  - typedef reg_idx_t (logic [4:0])
  - typedef reg_data_t (logic [DW-1:0])
- Sub-module: instantiate the existing decoder5_32 for write-enable generation (e = RegWrite, addr = WriteRegister).
- Storage and scoreboard are flops in this module.
- Read muxes are behavioural 32:1 muxes.

Test Plan:
- Reset then read: assert rst_n=0 mid-cycle, read X0..X30 -> all reads 0. Pending outputs 0 immediately, before any clk edge.
- Basic write/read: write X5 = 0xDEADBEEF_CAFEF00D, next cycle ReadRegister1=5 -> ReadData1 = 0xDEADBEEF_CAFEF00D; ReadRegister2=6 -> 0.
- XZR: write X31 = 0xFFFF_FFFF_FFFF_FFFF with RegWrite=1, read 31 on both ports the same cycle and the next -> 0; rd1_pending stays 0 after issue_rd=31.
- Bypass: X7 holds 0x1, same cycle RegWrite=1, WriteRegister=7, WriteData=0x22, both read ports=7 -> ReadData1 = ReadData2 = 0x22.
- Scoreboard:
  - issue_rd=3 at cycle 0 -> rd1_pending=1 (ReadRegister1=3) from cycle 1.
  - Writeback X3 at cycle 4 -> rd1_pending=0 in cycle 4 via bypass, and the pending bit clear from cycle 5.
- Set/clear collision: pending[9]=1; same edge issue_rd=9 and RegWrite to X9 -> pending[9] remains 1 after the edge. The array holds the written data.
